// File: rtl/blk_match_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | blk_match_pkg : shared types and helpers for the block-match scheduler   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package blk_match_pkg;

    typedef enum logic [1:0] {
        SCHED_IDLE  = 2'd0,
        SCHED_RUN   = 2'd1,
        SCHED_DRAIN = 2'd2
    } sched_state_t;

    localparam int DEF_FRAME_W  = 240;
    localparam int DEF_FRAME_H  = 240;
    localparam int DEF_BLK_W    = 16;
    localparam int BLKS_PER_ROW = DEF_FRAME_W / DEF_BLK_W;
    localparam int BLK_ROWS     = DEF_FRAME_H / DEF_BLK_W;

    // Like $clog2 but never returns 0, so a single-entry index still has a bit.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage
`default_nettype wire

// File: rtl/blk_match_scheduler_credit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | blk_credit_counter : saturating up/down counter with programmable init   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module blk_credit_counter #(
    parameter int WIDTH    = 3,
    parameter int MAX_VAL  = 6,
    parameter int INIT_VAL = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] C_MAX  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] C_INIT = WIDTH'(INIT_VAL);

    logic [WIDTH-1:0] r_count;

    // Simultaneous inc and dec cancel; inc at max and dec at zero are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= C_INIT;
        end else if (inc && !dec && (r_count != C_MAX)) begin
            r_count <= r_count + 1'b1;
        end else if (dec && !inc && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/blk_match_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | blk_match_scheduler : raster-order job issue / in-order result collect   |
// | across NUM_ENG matcher engines. Optional stats: SCHED_STATS_EN.          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module blk_match_scheduler
    import blk_match_pkg::*;
#(
    parameter int FRAME_W      = 240,
    parameter int FRAME_H      = 240,
    parameter int BLK_W        = 16,
    parameter int NUM_ENG      = 4,
    parameter int BUF_BLK_ROWS = 6
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       frame_start,
    output logic [NUM_ENG-1:0]                         job_valid,
    input  logic [NUM_ENG-1:0]                         job_ready,
    output logic [clog2_min1(FRAME_W/BLK_W)-1:0]       job_col,
    output logic [clog2_min1(FRAME_H/BLK_W)-1:0]       job_row,
    input  logic [NUM_ENG-1:0]                         res_valid,
    output logic [NUM_ENG-1:0]                         res_ack,
    output logic [clog2_min1(NUM_ENG)-1:0]             res_sel,
    output logic                                       xors_valid,
    input  logic                                       row_released,
    output logic                                       busy,
    output logic                                       frame_done
`ifdef SCHED_STATS_EN
    ,
    output logic [31:0]                                stall_credit_cnt,
    output logic [31:0]                                stall_eng_cnt
`endif
);

    localparam int COLS  = FRAME_W / BLK_W;
    localparam int ROWS  = FRAME_H / BLK_W;
    localparam int COL_W = clog2_min1(COLS);
    localparam int ROW_W = clog2_min1(ROWS);
    localparam int PTR_W = clog2_min1(NUM_ENG);
    localparam int CRD_W = clog2_min1(BUF_BLK_ROWS + 1);
    localparam int OUT_W = clog2_min1(NUM_ENG + 1);

    localparam logic [1:0] ST_IDLE  = 2'(SCHED_IDLE);
    localparam logic [1:0] ST_RUN   = 2'(SCHED_RUN);
    localparam logic [1:0] ST_DRAIN = 2'(SCHED_DRAIN);

    logic [1:0]       r_state;
    logic             r_armed;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic [PTR_W-1:0] r_issue_ptr;
    logic [PTR_W-1:0] r_coll_ptr;
    logic [CRD_W-1:0] w_credits;
    logic [OUT_W-1:0] w_outstanding;

    logic w_last_col, w_last_row, w_credit_ok, w_eng_free;
    logic w_can_issue, w_accept, w_collect, w_last_result;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(NUM_ENG - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign w_last_col  = (r_col == COL_W'(COLS - 1));
    assign w_last_row  = (r_row == ROW_W'(ROWS - 1));
    // A credit buys a whole block row, so only the row's first job needs one.
    assign w_credit_ok = (w_credits != '0) || (r_col != '0);
    assign w_eng_free  = (w_outstanding != OUT_W'(NUM_ENG));

    // r_armed holds off the first offer one cycle after entering RUN.
    assign w_can_issue = (r_state == ST_RUN) && r_armed && w_credit_ok && w_eng_free && !reset;
    assign w_accept    = w_can_issue && job_ready[r_issue_ptr];

    assign w_collect     = ((r_state == ST_RUN) || (r_state == ST_DRAIN)) && !reset
                           && (w_outstanding != '0) && res_valid[r_coll_ptr];
    assign w_last_result = w_collect && (r_state == ST_DRAIN) && (w_outstanding == OUT_W'(1));

    assign job_valid  = w_can_issue ? (NUM_ENG'(1) << r_issue_ptr) : '0;
    assign job_col    = r_col;
    assign job_row    = r_row;
    assign res_ack    = w_collect ? (NUM_ENG'(1) << r_coll_ptr) : '0;
    assign res_sel    = r_coll_ptr;
    assign xors_valid = w_collect;
    assign busy       = (r_state != ST_IDLE);
    assign frame_done = w_last_result;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_armed     <= 1'b0;
            r_col       <= '0;
            r_row       <= '0;
            r_issue_ptr <= '0;
            r_coll_ptr  <= '0;
        end else begin
            r_armed <= (r_state == ST_RUN);
            case (r_state)
                ST_IDLE: begin
                    if (frame_start) begin
                        r_state     <= ST_RUN;
                        r_col       <= '0;
                        r_row       <= '0;
                        r_issue_ptr <= '0;
                        r_coll_ptr  <= '0;
                    end
                end
                ST_RUN: begin
                    if (w_accept && w_last_col && w_last_row) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_last_result) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            if (w_accept) begin
                r_issue_ptr <= next_ptr(r_issue_ptr);
                if (w_last_col) begin
                    r_col <= '0;
                    r_row <= w_last_row ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
            if (w_collect) begin
                r_coll_ptr <= next_ptr(r_coll_ptr);
            end
        end
    end

    blk_credit_counter #(
        .WIDTH    (CRD_W),
        .MAX_VAL  (BUF_BLK_ROWS),
        .INIT_VAL (BUF_BLK_ROWS)
    ) u_credits (
        .clk   (clk),
        .reset (reset),
        .inc   (row_released),
        .dec   (w_accept && (r_col == '0)),
        .count (w_credits)
    );

    blk_credit_counter #(
        .WIDTH    (OUT_W),
        .MAX_VAL  (NUM_ENG),
        .INIT_VAL (0)
    ) u_outstanding (
        .clk   (clk),
        .reset (reset),
        .inc   (w_accept),
        .dec   (w_collect),
        .count (w_outstanding)
    );

`ifdef SCHED_STATS_EN
    logic        w_run_armed;
    logic [31:0] r_stall_credit;
    logic [31:0] r_stall_eng;

    assign w_run_armed = (r_state == ST_RUN) && r_armed;

    always_ff @(posedge clk) begin
        if (reset || ((r_state == ST_IDLE) && frame_start)) begin
            r_stall_credit <= '0;
            r_stall_eng    <= '0;
        end else begin
            if (w_run_armed && !w_credit_ok) begin
                r_stall_credit <= r_stall_credit + 32'd1;
            end
            if (w_run_armed && w_credit_ok && !w_accept) begin
                r_stall_eng <= r_stall_eng + 32'd1;
            end
        end
    end

    assign stall_credit_cnt = r_stall_credit;
    assign stall_eng_cnt    = r_stall_eng;
`endif

endmodule
`default_nettype wire

// File: doc/blk_match_scheduler.md
Name: blk_match_scheduler

Overview:
- Sequences one frame of block-matching jobs in raster order (block column, then block row) and dispatches them round-robin to NUM_ENG parallel matcher engines.
- Collects engine results in the same round-robin order, so results reach the xor-to-stream buffer strictly in raster order.
- Throttles issue with block-row credits returned by the downstream stream buffer, so that buffer never overflows.

Parameters:
- FRAME_W, 240, frame width in pixels.
- FRAME_H, 240, frame height in pixels.
- BLK_W, 16, block width/height in pixels; FRAME_W and FRAME_H are multiples of it.
- NUM_ENG, 4, matcher engine count; power of two, ≥1.
- BUF_BLK_ROWS, 6, block rows the downstream buffer holds (3 per ping-pong half).

Ports:
- clk, in, 1, clock.
- reset, in, 1, synchronous active-high reset.
- frame_start, in, 1, pulse: begin a new frame (ignored unless IDLE).
- job_valid, out, NUM_ENG, per-engine job request.
- job_ready, in, NUM_ENG, per-engine acceptance.
- job_col, out, $clog2(FRAME_W/BLK_W), block column of the offered job.
- job_row, out, $clog2(FRAME_H/BLK_W), block row of the offered job.
- res_valid, in, NUM_ENG, engine holds a finished result.
- res_ack, out, NUM_ENG, one-hot pop of the result being forwarded.
- res_sel, out, $clog2(NUM_ENG) (min 1), engine index for the external result mux.
- xors_valid, out, 1, pulse: selected result forwarded downstream this cycle.
- row_released, in, 1, pulse: downstream finished streaming one block row.
- busy, out, 1, frame in progress.
- frame_done, out, 1, one-cycle pulse when the last result is forwarded.

Behaviour:
- Reset: job_valid=0, res_ack=0, xors_valid=0, busy=0, frame_done=0, res_sel=0, job_col=job_row=0.
- Internal reset state: issue/collect pointers=0, credits=BUF_BLK_ROWS, outstanding=0, state IDLE.
- Reset mid-frame aborts immediately; no res_ack is issued after reset.

State machine:
- IDLE: on frame_start, go to RUN; busy=1 from the next cycle.
- RUN: issue and collect operate independently.
- RUN → DRAIN when the last job (col=max, row=max) is accepted.
- DRAIN: collect only. When the last result is forwarded, pulse frame_done and return to IDLE. busy stays 1 through that final cycle.

Issue:
- job_valid is one-hot at the issue pointer, asserted only when all hold: state RUN; credits>0; outstanding<NUM_ENG.
- Credit-check exception: credits are not required when the job is not the first (col≠0) of a block row.
- Handshake: job_valid&job_ready accepts the job. Then advance col (wrap to 0 and increment row at the last column), advance the issue pointer mod NUM_ENG, and increment outstanding.
- Accepting a col=0 job consumes one credit.
- job_col/job_row are stable while job_valid is high and not accepted.

Collect:
- Combinational check each cycle: if res_valid[collect_ptr], then res_ack[collect_ptr]=1 and xors_valid=1 that same cycle.
- Then advance collect_ptr and decrement outstanding.
- Results from other engines wait. res_sel=collect_ptr at all times.

Credits:
- row_released adds 1.
- Same-cycle consume and release leave credits unchanged.
- Saturate at BUF_BLK_ROWS; a release at max is ignored.
- Same-cycle issue and collect leave outstanding unchanged.

Timing and edge cases:
- Latency: frame_start → first job_valid is 2 cycles. Result valid → xors_valid is 0 cycles.
- frame_start while busy: ignored.
- NUM_ENG=1: pointers are constant 0.

Optional Feature:
- SCHED_STATS_EN defined:
  - Adds outputs stall_credit_cnt[31:0] and stall_eng_cnt[31:0].
  - stall_credit_cnt counts RUN cycles blocked by credits=0.
  - stall_eng_cnt counts RUN cycles blocked by outstanding=NUM_ENG or job_ready=0.
  - Both clear on frame_start and on reset.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package blk_match_pkg:
  - sched_state_t enum (IDLE, RUN, DRAIN).
  - Helper localparams BLKS_PER_ROW and BLK_ROWS computed from FRAME_W/FRAME_H/BLK_W.
  - Function clog2_min1.
- Sub-module blk_credit_counter: saturating up/down counter with init value; handles simultaneous inc/dec.

Test Plan:
- Frame sweep: NUM_ENG=4, defaults, engines ready always, results 5 cycles after accept, row_released 10 cycles after each 15 results → 225 jobs in raster order (0,0)…(14,14); jobs go to engines 0,1,2,3,0…; 225 xors_valid; frame_done once.
- Credit starvation: row_released never asserted → exactly 6 block rows (90 jobs) issued, then job_valid=0. One row_released pulse → 15 more jobs.
- Out-of-order completion: engine 1 finishes before engine 0 → no res_ack[1] until engine 0 is acked; xors_valid order is engine 0 then engine 1.
- Simultaneous events: same-cycle col=0 accept and row_released with credits=3 → credits stay 3. Same-cycle issue and collect → outstanding unchanged.
- Reset mid-frame: assert reset at job 40 → all outputs return to reset values next cycle. A subsequent frame_start restarts at (0,0) with credits=6.
- SCHED_STATS_EN: credit-starve scenario → stall_credit_cnt increments every blocked cycle; frame_start clears it.
